// File: rtl/calc_pkg.sv
// Shared widths, idle levels and channel helpers for the calculator input conditioner.
package calc_pkg;

  localparam int A_W              = 4;
  localparam int B_W              = 4;
  localparam int OPT_W            = 3;
  localparam int SW_W             = A_W + B_W + OPT_W;
  localparam int NUM_CH           = SW_W + 1;
  localparam int EQ_IDX           = SW_W;
  localparam logic EQ_IDLE        = 1'b1;
  localparam int DEBOUNCE_DEFAULT = 500000;

  // The equals button idles high (released); every switch idles low.
  function automatic logic chanRstVal(input int idx);
    return (idx == EQ_IDX) ? EQ_IDLE : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioning channel: a flop synchroniser followed by a persistence-count debouncer.
module debounce_bit #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic ac,
  input  logic d,
  output logic q
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   val_q, val_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];
  assign q = val_q;

  // A bounce back to the accepted level leaves cnt_d at its zero default.
  always_comb begin
    cnt_d = '0;
    val_d = val_q;
    if (s != val_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        val_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ac) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      val_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      cnt_q  <= cnt_d;
      val_q  <= val_d;
    end
  end

endmodule

// File: rtl/calc_input_conditioner.sv
// Debounces the calculator switches and equals button, and derives single-cycle event pulses.
module calc_input_conditioner
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             ac,
  input  logic [A_W-1:0]   raw_a,
  input  logic [B_W-1:0]   raw_b,
  input  logic [OPT_W-1:0] raw_opt,
  input  logic             raw_equal,
  output logic [A_W-1:0]   optA,
  output logic [B_W-1:0]   optB,
  output logic [OPT_W-1:0] doOpt,
  output logic             equalTo,
  output logic             eq_press,
  output logic             eq_release,
  output logic             field_change
);

  localparam logic [NUM_CH-1:0] RST_VEC = {EQ_IDLE, {SW_W{1'b0}}};

  logic [NUM_CH-1:0] rawBus;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] accDly_q;
  logic              eqPress_q, eqPress_d;
  logic              eqRelease_q, eqRelease_d;
  logic              fieldChange_q, fieldChange_d;

  assign rawBus = {raw_equal, raw_opt, raw_b, raw_a};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (chanRstVal(i))
    ) u_db (
      .clk(clk),
      .ac (ac),
      .d  (rawBus[i]),
      .q  (acc[i])
    );
  end

  // Edges are found against a one-cycle-old copy of the accepted levels.
  always_comb begin
    eqPress_d     = accDly_q[EQ_IDX] & ~acc[EQ_IDX];
    eqRelease_d   = ~accDly_q[EQ_IDX] & acc[EQ_IDX];
    fieldChange_d = |(acc[SW_W-1:0] ^ accDly_q[SW_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (ac) begin
      accDly_q      <= RST_VEC;
      eqPress_q     <= 1'b0;
      eqRelease_q   <= 1'b0;
      fieldChange_q <= 1'b0;
    end else begin
      accDly_q      <= acc;
      eqPress_q     <= eqPress_d;
      eqRelease_q   <= eqRelease_d;
      fieldChange_q <= fieldChange_d;
    end
  end

  assign optA         = acc[A_W-1:0];
  assign optB         = acc[A_W+B_W-1:A_W];
  assign doOpt        = acc[SW_W-1:A_W+B_W];
  assign equalTo      = acc[EQ_IDX];
  assign eq_press     = eqPress_q;
  assign eq_release   = eqRelease_q;
  assign field_change = fieldChange_q;

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Directed bench for calc_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_calc_input_conditioner;

  logic       clk;
  logic       ac;
  logic [3:0] raw_a, raw_b;
  logic [2:0] raw_opt;
  logic       raw_equal;
  logic [3:0] optA, optB;
  logic [2:0] doOpt;
  logic       equalTo, eq_press, eq_release, field_change;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic       ac;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opt;
    logic       eq;
    logic [3:0] expA;
    logic [3:0] expB;
    logic [2:0] expOpt;
    logic       expEq;
    logic       expPress;
    logic       expRel;
    logic       expFc;
  } vec_t;

  vec_t vecs[17];

  calc_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .ac          (ac),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .raw_opt     (raw_opt),
    .raw_equal   (raw_equal),
    .optA        (optA),
    .optB        (optB),
    .doOpt       (doOpt),
    .equalTo     (equalTo),
    .eq_press    (eq_press),
    .eq_release  (eq_release),
    .field_change(field_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] o, input logic e);
    ac        = r;
    raw_a     = a;
    raw_b     = b;
    raw_opt   = o;
    raw_equal = e;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int firstA, firstB, firstOpt, firstEq, fcEdge, fcCnt, prEdge, prCnt, rlEdge, rlCnt;
    int lowCnt, overlap, badDuring;

    // Reset with random raw inputs, then six quiet cycles at reset levels.
    for (int i = 0; i < 3; i++)
      vecs[i] = '{1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i < 9; i++)
      vecs[i] = '{1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    // raw_a 0->9: accepted on edge 6, field_change on edge 7 only.
    for (int k = 1; k <= 8; k++)
      vecs[8 + k] = '{1'b0, 4'd9, 4'd0, 3'd0, 1'b1, (k >= 6) ? 4'd9 : 4'd0, 4'd0, 3'd0,
                      1'b1, 1'b0, 1'b0, (k == 7)};

    applyStimulus(1'b1, 4'd0, 4'd0, 3'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].ac, vecs[i].a, vecs[i].b, vecs[i].opt, vecs[i].eq);
      tick();
      checkOutput($sformatf("row%0d optA", i), int'(optA), int'(vecs[i].expA));
      checkOutput($sformatf("row%0d optB", i), int'(optB), int'(vecs[i].expB));
      checkOutput($sformatf("row%0d doOpt", i), int'(doOpt), int'(vecs[i].expOpt));
      checkOutput($sformatf("row%0d equalTo", i), int'(equalTo), int'(vecs[i].expEq));
      checkOutput($sformatf("row%0d eq_press", i), int'(eq_press), int'(vecs[i].expPress));
      checkOutput($sformatf("row%0d eq_release", i), int'(eq_release), int'(vecs[i].expRel));
      checkOutput($sformatf("row%0d field_change", i), int'(field_change), int'(vecs[i].expFc));
    end

    // Bounce rejection on raw_b: 3-cycle glitches never reach the 4-cycle threshold.
    badDuring = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        raw_b = (c < 3) ? 4'd5 : 4'd0;
        tick();
        if (optB != 4'd0 || field_change) badDuring++;
      end
    end
    checkOutput("bounce optB held/no pulse", badDuring, 0);
    raw_b = 4'd5;
    firstB = -1; fcCnt = 0; fcEdge = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (firstB < 0 && optB == 4'd5) firstB = k;
      if (field_change) begin fcCnt++; if (fcEdge < 0) fcEdge = k; end
    end
    checkOutput("bounce optB settle edge", firstB, 6);
    checkOutput("bounce field_change count", fcCnt, 1);
    checkOutput("bounce field_change edge", fcEdge, 7);

    // Button press held 10 cycles, then release.
    raw_equal = 1'b0;
    firstEq = -1; prEdge = -1; prCnt = 0; rlEdge = -1; rlCnt = 0; lowCnt = 0; overlap = 0; fcCnt = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 10) raw_equal = 1'b1;
      if (firstEq < 0 && !equalTo) firstEq = k;
      if (!equalTo) lowCnt++;
      if (eq_press) begin prCnt++; if (prEdge < 0) prEdge = k; end
      if (eq_release) begin rlCnt++; if (rlEdge < 0) rlEdge = k; end
      if (eq_press && eq_release) overlap++;
      if (field_change) fcCnt++;
    end
    checkOutput("button equalTo fall edge", firstEq, 6);
    checkOutput("button equalTo low cycles", lowCnt, 10);
    checkOutput("button eq_press count", prCnt, 1);
    checkOutput("button eq_press edge", prEdge, 7);
    checkOutput("button eq_release count", rlCnt, 1);
    checkOutput("button eq_release edge", rlEdge, 17);
    checkOutput("button pulse overlap", overlap, 0);
    checkOutput("button no field_change", fcCnt, 0);

    // raw_opt and raw_equal change together: outputs and pulses coincide.
    raw_opt = 3'd2; raw_equal = 1'b0;
    firstOpt = -1; firstEq = -1; fcEdge = -1; fcCnt = 0; prEdge = -1; prCnt = 0; overlap = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (firstOpt < 0 && doOpt == 3'd2) firstOpt = k;
      if (firstEq < 0 && !equalTo) firstEq = k;
      if (field_change) begin fcCnt++; if (fcEdge < 0) fcEdge = k; end
      if (eq_press) begin prCnt++; if (prEdge < 0) prEdge = k; end
      if (field_change && eq_press) overlap++;
    end
    checkOutput("simul doOpt edge", firstOpt, 6);
    checkOutput("simul equalTo edge", firstEq, 6);
    checkOutput("simul field_change count", fcCnt, 1);
    checkOutput("simul eq_press count", prCnt, 1);
    checkOutput("simul same-cycle pulses", overlap, 1);
    checkOutput("simul pulse edge", prEdge, 7);

    // Reset mid-count discards the pending raw_a change.
    raw_a = 4'd3;
    for (int k = 0; k < 3; k++) tick();
    checkOutput("midreset optA before reset", int'(optA), 9);
    applyStimulus(1'b1, 4'd3, 4'd0, 3'd0, 1'b1);
    tick();
    checkOutput("midreset optA in reset", int'(optA), 0);
    checkOutput("midreset doOpt in reset", int'(doOpt), 0);
    checkOutput("midreset equalTo in reset", int'(equalTo), 1);
    ac = 1'b0;
    firstA = -1; fcEdge = -1; fcCnt = 0; prCnt = 0; rlCnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (firstA < 0 && optA == 4'd3) firstA = k;
      if (field_change) begin fcCnt++; if (fcEdge < 0) fcEdge = k; end
      if (eq_press) prCnt++;
      if (eq_release) rlCnt++;
    end
    checkOutput("midreset optA settle edge", firstA, 6);
    checkOutput("midreset field_change edge", fcEdge, 7);
    checkOutput("midreset field_change count", fcCnt, 1);
    checkOutput("midreset no button pulses", prCnt + rlCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/calc_input_conditioner.md
# calc_input_conditioner

Input conditioning stage placed directly upstream of the arithmetic/logic calculator. Synchronises and debounces the raw board switches (operand A, operand B, operation select) and the "equals" push-button. Delivers glitch-free stable levels plus single-cycle event pulses, so the calculator core sees one clean transition per physical action.

## Interface

**Parameters**
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth per input bit; legal range 2..3.
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive cycles a new level must persist before acceptance; minimum 2.

**Ports**
- `clk`  in  1: single clock; everything is registered on its rising edge.
- `ac`  in  1: reset, synchronous, active-high.
- `raw_a`  in  4: operand A slide switches, asynchronous.
- `raw_b`  in  4: operand B slide switches, asynchronous.
- `raw_opt`  in  3: operation select switches, asynchronous.
- `raw_equal`  in  1: equals push-button, active-low (0 = pressed), asynchronous.
- `optA`  out  4: debounced operand A.
- `optB`  out  4: debounced operand B.
- `doOpt`  out  3: debounced operation select.
- `equalTo`  out  1: debounced button level, active-low.
- `eq_press`  out  1: one-cycle pulse on debounced press (equalTo 1→0).
- `eq_release`  out  1: one-cycle pulse on debounced release (equalTo 0→1).
- `field_change`  out  1: one-cycle pulse when any bit of optA/optB/doOpt changes.

## Operation

- All 12 raw bits are handled independently by identical per-bit channels.
- Each channel:
  - Passes the raw bit through a `SYNC_STAGES` flop chain, giving `s`.
  - Holds the accepted value `q` and a counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s == q`: `cnt` ← 0.
  - If `s != q` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt+1`.
  - If `s != q` and `cnt == DEBOUNCE_CYCLES-1`: `q` ← `s` and `cnt` ← 0.
  - Any bounce back to `q` restarts the count from 0. There is no partial credit.
- Pulse generation:
  - A registered copy `q_d` of each accepted bit is kept.
  - `eq_press` = `q_d(equal) & ~q(equal)`.
  - `eq_release` = `~q_d(equal) & q(equal)`.
  - `field_change` = OR over the 11 switch bits of (`q ^ q_d`).
  - All three pulses are registered outputs.
- Simultaneous events:
  - Several bits settling on the same edge produce a single `field_change` cycle.
  - `field_change` and `eq_press` may be asserted in the same cycle.
- `eq_press`/`eq_release` can never be high together. Consecutive presses are separated by at least `DEBOUNCE_CYCLES` cycles.
- Reset (`ac`=1 at a clk edge):
  - Synchroniser flops, `q_d` and `q` reset to 0, except the equal channel, which resets to 1 (released).
  - All counters reset to 0 and all pulses to 0.
  - Reset mid-count discards the pending transition.
  - No pulse is emitted on the first cycle after reset, because `q_d` equals `q` at reset.

## Timing

- Latency, raw level change to stable output: `SYNC_STAGES + DEBOUNCE_CYCLES` clk edges, provided the raw level is held steady throughout.
- Pulses assert on the edge after the output change (+1 cycle) and last exactly 1 cycle.
- Reset values:
  - `optA`=0, `optB`=0, `doOpt`=0
  - `equalTo`=1
  - `eq_press`=0, `eq_release`=0, `field_change`=0
- `cnt` saturation is impossible: the counter clears whenever it reaches `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- A raw pulse shorter than `DEBOUNCE_CYCLES` cycles (after sync) is fully rejected.

## Structure

- Shared package `calc_pkg`:
  - Field widths `A_W`=4, `B_W`=4, `OPT_W`=3.
  - Localparam `EQ_IDLE`=1'b1 (released level).
  - Default `DEBOUNCE_CYCLES`.
- One sub-module, `debounce_bit`:
  - Parameters `SYNC_STAGES`, `DEBOUNCE_CYCLES`, `RST_VAL`.
  - Ports `clk`, `ac`, `d`, `q`.
  - Instantiated 12 times via generate.
- Edge/pulse logic lives in the top module.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.

1. **Reset values.** Assert `ac` for 3 cycles with random raw inputs → `optA`=0, `optB`=0, `doOpt`=0, `equalTo`=1, no pulses for 6 cycles after release with raw inputs matching reset values.
2. **Clean switch change.** `raw_a` 0→9 held → `optA`=9 exactly 6 edges later; `field_change`=1 for exactly one cycle on the 7th edge.
3. **Bounce rejection.** `raw_b` toggles 0→5→0 with 3-cycle glitches, repeated 4 times, then held at 5 → `optB` stays 0 during bouncing, becomes 5 six edges after the final hold begins; only one `field_change`.
4. **Button press/release.** `raw_equal` 1→0 held 10 cycles, then 1 → `eq_press` one cycle, `equalTo`=0 for 10 cycles, then `eq_release` one cycle; pulses never overlap.
5. **Simultaneous settle.** `raw_opt` 0→2 and `raw_equal` 1→0 on the same edge → `doOpt`=2 and `equalTo`=0 on the same cycle; `field_change` and `eq_press` both pulse once, in the same cycle.
6. **Reset mid-count.** `raw_a`=3 held 3 cycles, `ac` pulsed for 1 cycle, `raw_a` still 3 → `optA` stays 0 until 6 edges after reset deasserts, then becomes 3.
